// File: rtl/page_table_lookup_pkg.sv
// Shared types for the page-table search engine: FSM state encoding and index sizing.
package page_table_lookup_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } pt_state_e;

  // Index width for a table of the given depth (depth is always >= 2).
  function automatic int pt_idx_w(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/pt_sat_counter.sv
// Saturating up-counter for lookup statistics; sticks at all-ones.
module pt_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/page_table_lookup.sv
// Page-table search engine: scans a register-array table one entry per clock and
// returns the first valid VPN match or a miss fault, with saturating hit/miss stats.
module page_table_lookup
  import page_table_lookup_pkg::*;
#(
  parameter int VPN_W   = 4,
  parameter int PPN_W   = 4,
  parameter int ENTRIES = 8,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         LOOKUP_RQST,
  input  logic [VPN_W-1:0]             LOOKUP_ADDR,
  output logic                         LOOKUP_BUSY,
  output logic                         LOOKUP_COMPLETE,
  output logic                         LOOKUP_HIT,
  output logic [VPN_W+PPN_W-1:0]       LOOKUP_RETURN,
  input  logic                         LOAD_EN,
  input  logic [pt_idx_w(ENTRIES)-1:0] LOAD_IDX,
  input  logic                         LOAD_VALID,
  input  logic [VPN_W-1:0]             LOAD_VPN,
  input  logic [PPN_W-1:0]             LOAD_PPN,
  input  logic                         INVALIDATE_ALL,
  output logic [CNT_W-1:0]             HIT_COUNT,
  output logic [CNT_W-1:0]             MISS_COUNT
);

  localparam int                IDX_W    = pt_idx_w(ENTRIES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } pt_entry_t;

  // Table storage: valid bits reset, payload fields do not.
  logic [ENTRIES-1:0] valid_q;
  logic [VPN_W-1:0]   vpn_q [ENTRIES];
  logic [PPN_W-1:0]   ppn_q [ENTRIES];
  logic [ENTRIES-1:0] load_sel;

  pt_state_e                state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [VPN_W-1:0]         req_vpn_q, req_vpn_d;
  logic [VPN_W+PPN_W-1:0]   ret_q, ret_d;
  logic                     hit_q, hit_d;
  logic                     complete_q, complete_d;
  logic                     busy_q, busy_d;
  pt_entry_t                cur;
  logic                     match;
  logic                     hit_inc, miss_inc;

  // Out-of-range load indices decode to no entry and are dropped.
  always_comb begin
    load_sel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      load_sel[i] = LOAD_EN && (LOAD_IDX == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (load_sel[i]) begin
          valid_q[i] <= LOAD_VALID;
        end else if (INVALIDATE_ALL) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (load_sel[i]) begin
        vpn_q[i] <= LOAD_VPN;
        ppn_q[i] <= LOAD_PPN;
      end
    end
  end

  // Entry under comparison reflects table contents before this cycle's edge.
  always_comb begin
    cur = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur = '{valid: valid_q[i], vpn: vpn_q[i], ppn: ppn_q[i]};
      end
    end
  end

  assign match = cur.valid && (cur.vpn == req_vpn_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    req_vpn_d  = req_vpn_q;
    ret_d      = ret_q;
    hit_d      = hit_q;
    complete_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (LOOKUP_RQST) begin
          req_vpn_d = LOOKUP_ADDR;
          idx_d     = '0;
          state_d   = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (match) begin
          ret_d      = {cur.vpn, cur.ppn};
          hit_d      = 1'b1;
          complete_d = 1'b1;
          state_d    = ST_DONE;
        end else if (idx_q == LAST_IDX) begin
          ret_d      = {req_vpn_q, {PPN_W{1'b0}}};
          hit_d      = 1'b0;
          complete_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      req_vpn_q  <= '0;
      ret_q      <= '0;
      hit_q      <= 1'b0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      req_vpn_q  <= req_vpn_d;
      ret_q      <= ret_d;
      hit_q      <= hit_d;
      complete_q <= complete_d;
      busy_q     <= busy_d;
    end
  end

  assign LOOKUP_BUSY     = busy_q;
  assign LOOKUP_COMPLETE = complete_q;
  assign LOOKUP_HIT      = hit_q;
  assign LOOKUP_RETURN   = ret_q;

  assign hit_inc  = (state_q == ST_DONE) && hit_q;
  assign miss_inc = (state_q == ST_DONE) && !hit_q;

  pt_sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_inc),
    .count (HIT_COUNT)
  );

  pt_sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc),
    .count (MISS_COUNT)
  );

endmodule
